// File: rtl/seq_det_ctrl_if.sv
// Control/data bundle for the serial pattern detector: frame config, bit stream, status.
// Latency: none, pure wiring.
// Backpressure: none; bits are qualified by seq_valid only and are never stalled.
interface seq_det_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
);
  logic             start;
  logic [3:0]       cfg_pattern;
  logic             cfg_overlap;
  logic [LEN_W-1:0] cfg_len;
  logic             seq;
  logic             seq_valid;
  logic             busy;
  logic             det;
  logic [CNT_W-1:0] det_count;
  logic             ovf;
  logic             done;

  // Frame controller side: issues config and bits, observes status.
  modport master (
    output start, cfg_pattern, cfg_overlap, cfg_len, seq, seq_valid,
    input  busy, det, det_count, ovf, done
  );

  // Detector side.
  modport slave (
    input  start, cfg_pattern, cfg_overlap, cfg_len, seq, seq_valid,
    output busy, det, det_count, ovf, done
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Framed 4-bit serial pattern detector with saturating match counter and overlap option.
// Latency: det one cycle after the sampling edge; done one cycle after the last frame bit.
// Backpressure: none; idle cycles (seq_valid=0) freeze the shift history and bit count.
module seq_det_ctrl #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic          clk,
  input  logic          arstn,
  seq_det_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;

  // Frame configuration captured when start is accepted.
  logic [3:0]       pat_q;
  logic             ovl_q;
  logic [LEN_W-1:0] len_q;

  // Shift history, number of history bits that count toward a match (0..4), bits consumed.
  logic [3:0]       hist;
  logic [2:0]       fill;
  logic [LEN_W-1:0] bit_cnt;

  logic             det_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             take_bit;
  logic             match;
  logic [3:0]       hist_sh;
  logic [2:0]       fill_inc;
  logic [LEN_W-1:0] bit_inc;

  assign hist_sh  = {hist[2:0], bus.seq};
  assign fill_inc = (fill >= 3'd4) ? 3'd4 : fill + 3'd1;
  assign bit_inc  = bit_cnt + 1'b1;
  // Match is judged on the history as it will be after this bit shifts in.
  assign match    = take_bit && (hist_sh == pat_q) && (fill_inc == 3'd4);

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the start-accept and bit-consume strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    take_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = (bus.cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.seq_valid) begin
          take_bit = 1'b1;
          if (bit_inc == len_q) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: config latch, history shift, match pulse and saturating counter.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      len_q   <= '0;
      hist    <= '0;
      fill    <= '0;
      bit_cnt <= '0;
      det_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      det_q <= match;
      if (accept) begin
        pat_q   <= bus.cfg_pattern;
        ovl_q   <= bus.cfg_overlap;
        len_q   <= bus.cfg_len;
        hist    <= '0;
        fill    <= '0;
        bit_cnt <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (take_bit) begin
        hist    <= hist_sh;
        bit_cnt <= bit_inc;
        // Non-overlapping mode restarts the fill so the next match needs four fresh bits.
        fill    <= (match && !ovl_q) ? 3'd0 : fill_inc;
        if (match) begin
          if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
          else                  cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.det       = det_q;
  assign bus.det_count = cnt_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: two instances (default and 2-bit counter) share stimulus.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised through seq_valid gaps inside a frame.
module tb_seq_det_ctrl;

  logic clk;
  logic arstn;
  int   n_cmp;
  int   n_fail;
  logic [7:0] bits;
  logic [7:0] exp_det;

  seq_det_ctrl_if #(.CNT_W(8), .LEN_W(8)) ia ();
  seq_det_ctrl_if #(.CNT_W(2), .LEN_W(8)) ib ();

  seq_det_ctrl #(.CNT_W(8), .LEN_W(8)) u_dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (ia)
  );

  seq_det_ctrl #(.CNT_W(2), .LEN_W(8)) u_dut2 (
    .clk   (clk),
    .arstn (arstn),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic v);
    ia.seq = b;  ia.seq_valid = v;
    ib.seq = b;  ib.seq_valid = v;
    step();
    ia.seq_valid = 1'b0;
    ib.seq_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] pat, input logic ovl, input logic [7:0] len);
    ia.cfg_pattern = pat;  ia.cfg_overlap = ovl;  ia.cfg_len = len;
    ib.cfg_pattern = pat;  ib.cfg_overlap = ovl;  ib.cfg_len = len;
  endtask

  task automatic start_frame(input logic [3:0] pat, input logic ovl, input logic [7:0] len);
    set_cfg(pat, ovl, len);
    ia.start = 1'b1;
    ib.start = 1'b1;
    step();
    ia.start = 1'b0;
    ib.start = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    arstn  = 1'b0;
    ia.start = 1'b0;  ia.seq = 1'b0;  ia.seq_valid = 1'b0;
    ib.start = 1'b0;  ib.seq = 1'b0;  ib.seq_valid = 1'b0;
    set_cfg(4'h0, 1'b0, 8'd0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", ia.busy, 0);
    chk("rst_det", ia.det, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_cnt", ia.det_count, 0);
    chk("rst_ovf", ia.ovf, 0);
    chk("rst_cnt_b", ib.det_count, 0);
    arstn = 1'b1;
    step();
    chk("idle_busy", ia.busy, 0);

    // Non-overlapping 1101 over 1,1,0,1,1,0,1,1: single hit after bit 4.
    start_frame(4'b1101, 1'b0, 8'd8);
    chk("nov_busy", ia.busy, 1);
    chk("nov_cnt0", ia.det_count, 0);
    bits    = 8'b1101_1011;
    exp_det = 8'b0001_0000;
    for (int i = 0; i < 8; i++) begin
      drive_bit(bits[7-i], 1'b1);
      chk("nov_det", ia.det, exp_det[7-i]);
      chk("nov_done", ia.done, (i == 7));
    end
    chk("nov_cnt", ia.det_count, 1);
    chk("nov_busy_end", ia.busy, 0);
    step();
    chk("nov_done_clr", ia.done, 0);
    chk("nov_cnt_hold", ia.det_count, 1);

    // Same stream, overlapping: hits after bits 4 and 7.
    start_frame(4'b1101, 1'b1, 8'd8);
    exp_det = 8'b0001_0010;
    for (int i = 0; i < 8; i++) begin
      drive_bit(bits[7-i], 1'b1);
      chk("ovl_det", ia.det, exp_det[7-i]);
    end
    chk("ovl_cnt", ia.det_count, 2);
    chk("ovl_ovf", ia.ovf, 0);
    chk("ovl_done", ia.done, 1);
    step();

    // Eight zeros against 0000, overlapping: five hits; 2-bit counter saturates at 3.
    start_frame(4'b0000, 1'b1, 8'd8);
    exp_det = 8'b0001_1111;
    for (int i = 0; i < 8; i++) begin
      drive_bit(1'b0, 1'b1);
      chk("sat_det", ib.det, exp_det[7-i]);
    end
    chk("sat_cnt_b", ib.det_count, 3);
    chk("sat_ovf_b", ib.ovf, 1);
    chk("sat_cnt_a", ia.det_count, 5);
    chk("sat_ovf_a", ia.ovf, 0);
    step();
    chk("sat_ovf_hold", ib.ovf, 1);
    chk("sat_cnt_hold", ib.det_count, 3);

    // len=4 with 3-cycle valid gaps carrying seq=1; history must not move during gaps.
    start_frame(4'b1101, 1'b0, 8'd4);
    chk("sat_clr_ovf", ib.ovf, 0);
    bits = 8'b0000_1101;
    for (int i = 0; i < 4; i++) begin
      drive_bit(bits[3-i], 1'b1);
      chk("gap_det", ia.det, (i == 3));
      chk("gap_done", ia.done, (i == 3));
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          drive_bit(1'b1, 1'b0);
          chk("gap_idle_det", ia.det, 0);
          chk("gap_idle_busy", ia.busy, 1);
        end
      end
    end
    chk("gap_cnt", ia.det_count, 1);
    step();

    // Zero-length frame goes straight to DONE and clears the previous count.
    start_frame(4'b1010, 1'b0, 8'd0);
    chk("len0_done", ia.done, 1);
    chk("len0_busy", ia.busy, 0);
    chk("len0_cnt", ia.det_count, 0);
    step();
    chk("len0_done_clr", ia.done, 0);
    chk("len0_busy_idle", ia.busy, 0);

    // start and new cfg during RUN must not restart or reconfigure the frame.
    start_frame(4'b1101, 1'b0, 8'd4);
    drive_bit(1'b1, 1'b1);
    set_cfg(4'b1111, 1'b1, 8'd8);
    ia.start = 1'b1;
    ib.start = 1'b1;
    drive_bit(1'b1, 1'b0);
    ia.start = 1'b0;
    ib.start = 1'b0;
    chk("ign_busy", ia.busy, 1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    chk("ign_det_early", ia.det, 0);
    drive_bit(1'b1, 1'b1);
    chk("ign_det", ia.det, 1);
    chk("ign_done", ia.done, 1);
    chk("ign_cnt", ia.det_count, 1);
    step();

    // Reset mid-frame after bit 3: immediate clear, no done, then a clean frame.
    start_frame(4'b1101, 1'b0, 8'd8);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    chk("mid_busy", ia.busy, 1);
    arstn = 1'b0;
    #1;
    chk("mid_rst_busy", ia.busy, 0);
    chk("mid_rst_det", ia.det, 0);
    chk("mid_rst_done", ia.done, 0);
    chk("mid_rst_cnt", ia.det_count, 0);
    for (int k = 0; k < 2; k++) begin
      ia.seq = 1'b1;  ia.seq_valid = 1'b1;
      ib.seq = 1'b1;  ib.seq_valid = 1'b1;
      step();
      chk("mid_hold_done", ia.done, 0);
      chk("mid_hold_busy", ia.busy, 0);
    end
    ia.seq_valid = 1'b0;
    ib.seq_valid = 1'b0;
    arstn = 1'b1;
    step();
    step();
    chk("post_rst_idle", ia.busy, 0);
    chk("post_rst_done", ia.done, 0);
    start_frame(4'b1101, 1'b0, 8'd8);
    bits    = 8'b1101_1011;
    exp_det = 8'b0001_0000;
    for (int i = 0; i < 8; i++) begin
      drive_bit(bits[7-i], 1'b1);
      chk("post_det", ia.det, exp_det[7-i]);
    end
    chk("post_done", ia.done, 1);
    chk("post_cnt", ia.det_count, 1);
    step();
    chk("post_idle", ia.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the detection-counter width.
REQ-002 The block SHALL have parameter LEN_W, default 8, setting the frame-length width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 arstn  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request to begin a frame; sampled only in IDLE.
REQ-006 cfg_pattern  input  4  target sequence, MSB is the first bit received; latched on accepted start.
REQ-007 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping; latched on accepted start.
REQ-008 cfg_len  input  LEN_W  frame length in valid bits; latched on accepted start.
REQ-009 seq  input  1  serial data bit.
REQ-010 seq_valid  input  1  seq is sampled only when this is 1.
REQ-011 busy  output  1  high in RUN.
REQ-012 det  output  1  registered one-cycle detection pulse.
REQ-013 det_count  output  CNT_W  detections in the current or last frame.
REQ-014 ovf  output  1  sticky; det_count saturated.
REQ-015 done  output  1  one-cycle frame-complete pulse.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 IDLE & start & cfg_len!=0: latch cfg_*, clear det_count, ovf, history, fill and bit counters; next state RUN.
REQ-018 IDLE & start & cfg_len==0: latch cfg_*, clear det_count and ovf; next state DONE; no bits consumed.
REQ-019 start SHALL be ignored in RUN and DONE; cfg_* changes after acceptance SHALL have no effect on the frame.
REQ-020 RUN & seq_valid: hist <= {hist[2:0], seq}; fill <= min(fill+1, 4); bit counter +1.
REQ-021 RUN & !seq_valid: hist, fill and bit counter SHALL hold, and det SHALL be 0 next cycle.
REQ-022 Match condition: the post-shift hist equals the latched pattern and the post-increment fill == 4.
REQ-023 On a match, det SHALL be 1 in the cycle after the sampling edge (latency 1) and det_count SHALL increment on that same edge.
REQ-024 Non-overlap mode: on a match, fill SHALL reset to 0, so the next match needs 4 new valid bits.
REQ-025 Overlap mode: fill SHALL NOT reset on a match.
REQ-026 det_count SHALL saturate at 2^CNT_W-1; a match at saturation SHALL set ovf, still pulse det, and hold the count.
REQ-027 When the valid bit that makes the bit counter equal the latched cfg_len is sampled, next state SHALL be DONE; a match on that bit still pulses det in the DONE cycle.
REQ-028 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-029 det_count and ovf SHALL hold after DONE until the next accepted start.
REQ-030 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both are registered-state decodes.
REQ-031 Every case statement SHALL have a default; unused or illegal encodings SHALL go to IDLE.

Reset
REQ-032 arstn low SHALL immediately force IDLE; busy=0, det=0, done=0, det_count=0, ovf=0, and hist, fill, bit counter and latched cfg_* all 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-034 pattern=1101, overlap=0, len=8, valid bits 1,1,0,1,1,0,1,1 -> det after bit 4 only; det_count=1; done one cycle after bit 8.
REQ-035 Same stimulus with overlap=1 -> det after bits 4 and 7; det_count=2; ovf=0.
REQ-036 CNT_W=2, pattern=0000, overlap=1, len=8, eight 0s -> det after bits 4..8 (5 pulses); det_count=3; ovf=1.
REQ-037 pattern=1101, len=4, bits 1,1,0,1 with seq_valid=0 gaps of 3 cycles between bits -> single det only after 4th valid bit; busy high throughout; done follows.
REQ-038 len=0 start -> next cycle done=1, busy never high, det_count=0; start pulsed during RUN -> no effect on count or length.
REQ-039 Drop arstn after bit 3 of a len=8 frame -> outputs 0 immediately, no done; a fresh start then runs a full, correct frame.
